core_dbus_bridge: RTL and testbench

- Sits directly downstream of the core's data-memory port, between the MEM stage's RAM request outputs and a shared Wishbone-classic data bus.
- Converts the core's single-cycle RAM request into a multi-cycle bus transaction.
- Holds the pipeline with a stall while the transaction is in flight.
- Returns read data and an error flag to the core, and counts completed transactions.

---
 rtl/core_dbus_bridge.sv | 162 ++++++++++++++++
 tb/tb_core_dbus_bridge.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_dbus_bridge.sv
// core_dbus_bridge
//   Bridges the core's single-cycle data-memory request onto a shared
//   Wishbone-classic data bus.
//
//   Behaviour:
//     - Stalls the pipeline while a bus transaction is in flight.
//     - Returns read data and an error flag to the core.
//     - Counts completed transactions.
//
//   Optional feature (macro BUS_TIMEOUT_EN):
//     - Defined: a wait counter forces a transaction to end with an error
//       after TIMEOUT_CYCLES bus cycles with neither ack nor err.
//     - Undefined: the bridge waits on the bus indefinitely.
//
//   Ports:
//     clk_i, rst_i            clock, asynchronous active-low reset
//     core_req_i/we_i         core access request (level) and direction
//     core_addr_i/wdata_i     core byte address and write data
//     core_sel_i              core byte enables
//     core_rdata_o/err_o      access result, valid in DONE and held afterwards
//     core_stall_o            pipeline hold request
//     wb_cyc_o/stb_o/we_o     Wishbone cycle, strobe, write enable
//     wb_adr_o/dat_o/sel_o    Wishbone address, write data, byte selects
//     wb_dat_i/ack_i/err_i    Wishbone read data, acknowledge, error
//     txn_count_o             completed transactions (wraps at 16 bits)
module core_dbus_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    core_req_i,
  input  logic                    core_we_i,
  input  logic [ADDR_WIDTH-1:0]   core_addr_i,
  input  logic [DATA_WIDTH-1:0]   core_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] core_sel_i,
  output logic [DATA_WIDTH-1:0]   core_rdata_o,
  output logic                    core_err_o,
  output logic                    core_stall_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i,
  output logic [15:0]             txn_count_o
);

  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_BUS  = 2'd1;
  localparam logic [1:0] STATE_DONE = 2'd2;

  logic [1:0] state;
  logic       bus_finish;
  logic       bus_fail;

`ifdef BUS_TIMEOUT_EN
  localparam int WAIT_WIDTH = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                              $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [WAIT_WIDTH-1:0] wait_cnt;
  logic                  timeout_hit;

  // The counter holds the number of BUS cycles already spent without a
  // response, so this cycle is the TIMEOUT_CYCLES-th one when it reads
  // TIMEOUT_CYCLES-1.
  assign timeout_hit = (wait_cnt == WAIT_WIDTH'(TIMEOUT_CYCLES - 1));

  // Every entry to BUS comes from IDLE, so clearing while idle gives a
  // zero count on the first BUS cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wait_cnt <= '0;
    end else if (state == STATE_IDLE) begin
      wait_cnt <= '0;
    end else if ((state == STATE_BUS) && !bus_finish) begin
      wait_cnt <= wait_cnt + WAIT_WIDTH'(1);
    end
  end
`endif

  // Decide whether the bus phase ends this cycle. err beats ack, and a
  // real ack or err beats a timeout expiring in the same cycle.
  always_comb begin
    bus_finish = 1'b0;
    bus_fail   = 1'b0;
    if (state == STATE_BUS) begin
      if (wb_err_i) begin
        bus_finish = 1'b1;
        bus_fail   = 1'b1;
      end else if (wb_ack_i) begin
        bus_finish = 1'b1;
`ifdef BUS_TIMEOUT_EN
      end else if (timeout_hit) begin
        bus_finish = 1'b1;
        bus_fail   = 1'b1;
`endif
      end
    end
  end

  // Cycle and strobe decode straight from the state register, so an
  // asynchronous reset drops them at once.
  assign wb_cyc_o = (state == STATE_BUS);
  assign wb_stb_o = (state == STATE_BUS);

  // The stall is gated by reset because the idle stall follows the
  // request combinationally.
  always_comb begin
    core_stall_o = 1'b0;
    if (rst_i) begin
      case (state)
        STATE_IDLE: core_stall_o = core_req_i;
        STATE_BUS:  core_stall_o = 1'b1;
        default:    core_stall_o = 1'b0;
      endcase
    end
  end

  // DONE always returns to IDLE without sampling the request; the request
  // still visible there belongs to the access that just completed.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= STATE_IDLE;
      wb_we_o      <= 1'b0;
      wb_adr_o     <= '0;
      wb_dat_o     <= '0;
      wb_sel_o     <= '0;
      core_rdata_o <= '0;
      core_err_o   <= 1'b0;
      txn_count_o  <= '0;
    end else begin
      case (state)
        STATE_IDLE: begin
          if (core_req_i) begin
            wb_we_o  <= core_we_i;
            wb_adr_o <= core_addr_i;
            wb_dat_o <= core_wdata_i;
            wb_sel_o <= core_sel_i;
            state    <= STATE_BUS;
          end
        end
        STATE_BUS: begin
          if (bus_finish) begin
            core_err_o   <= bus_fail;
            core_rdata_o <= (bus_fail || wb_we_o) ? '0 : wb_dat_i;
            txn_count_o  <= txn_count_o + 16'd1;
            state        <= STATE_DONE;
          end
        end
        default: begin
          state <= STATE_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_dbus_bridge.sv
// tb_core_dbus_bridge
//   Scoreboard bench for core_dbus_bridge.
//
//   Processes:
//     - Driver: issues core requests. For each one it pushes the planned
//       slave response and the expected result computed from the bridge's
//       rules.
//     - Slave: answers bus cycles from the plan queue and toggles ack/err
//       randomly while the bus is idle.
//     - Monitor: checks bus stability during BUS, results at DONE, and that
//       results are held while idle.
//
//   Build options:
//     - With BUS_TIMEOUT_EN the bridge is built with TIMEOUT_CYCLES = 8.
module tb_core_dbus_bridge;

  localparam int TIMEOUT = 8;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    int unsigned wait_cycles;
    bit          ack;
    bit          err;
    logic [31:0] data;
  } plan_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        core_req_i = 1'b0;
  logic        core_we_i = 1'b0;
  logic [31:0] core_addr_i = '0;
  logic [31:0] core_wdata_i = '0;
  logic [3:0]  core_sel_i = '0;
  logic [31:0] core_rdata_o;
  logic        core_err_o;
  logic        core_stall_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic [15:0] txn_count_o;

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  plan_t       plan_q[$];
  logic [15:0] model_count = '0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;
  logic        prev_cyc = 1'b0;

  core_dbus_bridge #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .core_req_i(core_req_i),
    .core_we_i(core_we_i),
    .core_addr_i(core_addr_i),
    .core_wdata_i(core_wdata_i),
    .core_sel_i(core_sel_i),
    .core_rdata_o(core_rdata_o),
    .core_err_o(core_err_o),
    .core_stall_o(core_stall_o),
    .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o),
    .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o),
    .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i),
    .txn_count_o(txn_count_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=still running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Slave model: responds in BUS cycle wait_cycles+1 of each transaction.
  always begin : slave
    bit          active;
    int unsigned k;
    plan_t       cur;
    @(posedge clk_i);
    #1;
    if (!rst_i) begin
      active   = 1'b0;
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
    end else if (wb_cyc_o) begin
      if (!active) begin
        active = 1'b1;
        k      = 1;
        if (plan_q.size() > 0) begin
          cur = plan_q.pop_front();
        end else begin
          cur = '{wait_cycles: 0, ack: 1'b1, err: 1'b0, data: 32'h0};
        end
      end else begin
        k++;
      end
      if ((k == cur.wait_cycles + 1) && (cur.ack || cur.err)) begin
        wb_ack_i = cur.ack;
        wb_err_i = cur.err;
        wb_dat_i = cur.data;
      end else begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = $urandom;
      end
    end else begin
      active   = 1'b0;
      wb_ack_i = 1'($urandom_range(0, 1));
      wb_err_i = 1'($urandom_range(0, 1));
      wb_dat_i = $urandom;
    end
  end

  // Monitor: bus stability while in BUS, result at DONE, hold when idle.
  always @(negedge clk_i) begin : monitor
    exp_t e;
    if (!rst_i) begin
      prev_cyc = 1'b0;
    end else begin
      if (wb_cyc_o) begin
        checkOutput("bus_stb", wb_stb_o, 1);
        if (exp_q.size() > 0) begin
          e = exp_q[0];
          checkOutput("bus_adr", wb_adr_o, e.addr);
          checkOutput("bus_we", wb_we_o, e.we);
          checkOutput("bus_dat", wb_dat_o, e.wdata);
          checkOutput("bus_sel", wb_sel_o, e.sel);
        end else begin
          checkOutput("bus_pending_requests", exp_q.size(), 1);
        end
      end else if (prev_cyc) begin
        checkOutput("done_stb", wb_stb_o, 0);
        checkOutput("done_stall", core_stall_o, 0);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          model_count = model_count + 16'd1;
          last_rdata  = e.rdata;
          last_err    = e.err;
          checkOutput("done_rdata", core_rdata_o, e.rdata);
          checkOutput("done_err", core_err_o, e.err);
          checkOutput("done_count", txn_count_o, model_count);
        end else begin
          checkOutput("done_pending_requests", exp_q.size(), 1);
        end
      end else begin
        checkOutput("hold_rdata", core_rdata_o, last_rdata);
        checkOutput("hold_err", core_err_o, last_err);
        checkOutput("hold_count", txn_count_o, model_count);
      end
      prev_cyc = wb_cyc_o;
    end
  end

  // Issue one access at posedge+1; return at posedge+1 in the cycle after DONE.
  task automatic applyStimulus(input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] sel,
                               input int unsigned wait_cycles, input bit ack,
                               input bit err, input logic [31:0] data,
                               input bit keep_req);
    exp_t e;
    int   bus_cycles;
    int   stall_cnt;
    bit   done;
    e.we    = we;
    e.addr  = addr;
    e.wdata = wdata;
    e.sel   = sel;
`ifdef BUS_TIMEOUT_EN
    if (!(ack || err) || wait_cycles >= TIMEOUT) begin
      bus_cycles = TIMEOUT;
      e.err      = 1'b1;
      e.rdata    = '0;
    end else begin
      bus_cycles = int'(wait_cycles) + 1;
      e.err      = err;
      e.rdata    = (err || we) ? 32'h0 : data;
    end
`else
    bus_cycles = int'(wait_cycles) + 1;
    e.err      = err;
    e.rdata    = (err || we) ? 32'h0 : data;
`endif
    plan_q.push_back('{wait_cycles: wait_cycles, ack: ack, err: err, data: data});
    exp_q.push_back(e);
    core_req_i   = 1'b1;
    core_we_i    = we;
    core_addr_i  = addr;
    core_wdata_i = wdata;
    core_sel_i   = sel;
    stall_cnt = 0;
    done      = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_i);
      if (core_stall_o) begin
        stall_cnt++;
      end else begin
        done = 1'b1;
        break;
      end
    end
    checkOutput("access_completed", done, 1);
    checkOutput("stall_cycles", stall_cnt, bus_cycles + 1);
    @(posedge clk_i);
    #1;
    if (!keep_req) core_req_i = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    core_req_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      checkOutput("idle_cyc", wb_cyc_o, 0);
      checkOutput("idle_stall", core_stall_o, 0);
      @(posedge clk_i);
      #1;
    end
  endtask

  // Asynchronous reset while the bus cycle is open; returns at posedge+1.
  task automatic resetMidBus();
    @(posedge clk_i);
    #2;
    checkOutput("cyc_before_reset", wb_cyc_o, 1);
    #1;
    rst_i = 1'b0;
    #1;
    checkOutput("reset_cyc", wb_cyc_o, 0);
    checkOutput("reset_stb", wb_stb_o, 0);
    checkOutput("reset_stall", core_stall_o, 0);
    checkOutput("reset_count", txn_count_o, 0);
    checkOutput("reset_adr", wb_adr_o, 0);
    checkOutput("reset_rdata", core_rdata_o, 0);
    exp_q.delete();
    plan_q.delete();
    model_count = '0;
    last_rdata  = '0;
    last_err    = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i      = 1'b1;
    core_req_i = 1'b0;
  endtask

  initial begin
    // Reset with a pending request: stall must stay low.
    core_req_i = 1'b1;
    #12;
    checkOutput("por_stall", core_stall_o, 0);
    checkOutput("por_cyc", wb_cyc_o, 0);
    checkOutput("por_stb", wb_stb_o, 0);
    checkOutput("por_count", txn_count_o, 0);
    checkOutput("por_rdata", core_rdata_o, 0);
    checkOutput("por_err", core_err_o, 0);
    checkOutput("por_adr", wb_adr_o, 0);
    @(posedge clk_i);
    #1;
    rst_i      = 1'b1;
    core_req_i = 1'b0;
    idleCycles(2);

    $display("[TB] directed accesses");
    applyStimulus(1'b0, 32'h100, 32'h0, 4'hF, 0, 1'b1, 1'b0, 32'hCAFEBABE, 1'b0);
    idleCycles(1);
    applyStimulus(1'b1, 32'h204, 32'h12345678, 4'hF, 3, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0);
    applyStimulus(1'b0, 32'hFFFF0000, 32'h0, 4'hF, 1, 1'b1, 1'b1, 32'h55AA55AA, 1'b0);
    idleCycles(1);
    applyStimulus(1'b0, 32'h300, 32'h0, 4'h3, 0, 1'b1, 1'b0, 32'h11112222, 1'b1);
    applyStimulus(1'b1, 32'h304, 32'hA5A5A5A5, 4'hC, 2, 1'b1, 1'b0, 32'h0, 1'b0);
    idleCycles(2);
    applyStimulus(1'b0, 32'h400, 32'h0, 4'hF, TIMEOUT - 1, 1'b1, 1'b0, 32'h0BADF00D, 1'b0);
    idleCycles(1);

    $display("[TB] random accesses");
    for (int n = 0; n < 30; n++) begin
      int unsigned kind;
      kind = $urandom_range(0, 2);
      applyStimulus(1'($urandom_range(0, 1)), $urandom, $urandom,
                    4'($urandom_range(0, 15)), $urandom_range(0, 5),
                    (kind != 1), (kind != 0), $urandom,
                    1'($urandom_range(0, 1)));
      idleCycles($urandom_range(0, 2));
    end

    $display("[TB] unresponsive slave");
`ifdef BUS_TIMEOUT_EN
    applyStimulus(1'b0, 32'h500, 32'h0, 4'hF, 1000, 1'b0, 1'b0, 32'h0, 1'b0);
    idleCycles(1);
`else
    begin
      int stall_cnt;
      plan_q.push_back('{wait_cycles: 1000, ack: 1'b0, err: 1'b0, data: 32'h0});
      exp_q.push_back('{we: 1'b0, addr: 32'h500, wdata: 32'h0, sel: 4'hF,
                        rdata: 32'h0, err: 1'b1});
      core_req_i   = 1'b1;
      core_we_i    = 1'b0;
      core_addr_i  = 32'h500;
      core_wdata_i = 32'h0;
      core_sel_i   = 4'hF;
      stall_cnt = 0;
      repeat (120) begin
        @(negedge clk_i);
        if (core_stall_o) stall_cnt++;
      end
      checkOutput("stall_held_no_timeout", stall_cnt, 120);
      resetMidBus();
      idleCycles(2);
    end
`endif

    $display("[TB] reset during bus cycle");
    plan_q.push_back('{wait_cycles: 6, ack: 1'b1, err: 1'b0, data: 32'h77778888});
    exp_q.push_back('{we: 1'b1, addr: 32'h600, wdata: 32'h9ABCDEF0, sel: 4'h5,
                      rdata: 32'h0, err: 1'b0});
    core_req_i   = 1'b1;
    core_we_i    = 1'b1;
    core_addr_i  = 32'h600;
    core_wdata_i = 32'h9ABCDEF0;
    core_sel_i   = 4'h5;
    @(posedge clk_i);
    #1;
    @(posedge clk_i);
    #1;
    resetMidBus();
    idleCycles(2);
    applyStimulus(1'b0, 32'h700, 32'h0, 4'hF, 1, 1'b1, 1'b0, 32'h13579BDF, 1'b0);
    idleCycles(2);

    checkOutput("leftover_expectations", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
